// File: rtl/ahb_lite_pkg.sv
// AHB-Lite encodings and the phase-register type shared by the AHB-Lite initiator.
package ahb_lite_pkg;

    localparam int AHB_ADDR_W = 32;
    localparam int AHB_DATA_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic [AHB_ADDR_W-1:0] addr;
        logic [2:0]            size;
        logic [AHB_DATA_W-1:0] wdata;
    } phase_t;

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer initiator; the address phase of one command overlaps the data phase of the previous.
// Optional AHB_MASTER_HRESP_EN adds HRESP/rsp_error: an ERROR response aborts the pending address phase.
module ahb_lite_master
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_W = AHB_ADDR_W,
    parameter int DATA_W = AHB_DATA_W
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    // Command transfers on a rising HCLK edge where cmd_valid && cmd_ready; the
    // payload must stay stable while cmd_valid is high and cmd_ready low. The
    // response side has no ready: rsp_valid is a single-cycle strobe.
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
`ifdef AHB_MASTER_HRESP_EN
    output logic              rsp_error,
    input  logic              HRESP,
`endif
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic              HMASTLOCK,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY
);

    phase_t            a_q;
    phase_t            cmd_ph;
    logic              d_valid_q;
    logic              d_write_q;
    logic [DATA_W-1:0] hwdata_q;
    logic              accept;

    assign cmd_ready = !a_q.valid || HREADY;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        cmd_ph       = '0;
        cmd_ph.valid = 1'b1;
        cmd_ph.write = cmd_write;
        cmd_ph.addr  = AHB_ADDR_W'(cmd_addr);
        cmd_ph.size  = cmd_size;
        cmd_ph.wdata = AHB_DATA_W'(cmd_wdata);
    end

`ifdef AHB_MASTER_HRESP_EN
    // First cycle of a two-cycle ERROR: the queued address phase must not proceed.
    logic err_first;
    logic drop_q;
    logic drop_write_q;
    assign err_first = HRESP && !HREADY && a_q.valid && d_valid_q;
`endif

    // D keeps only what the data phase needs; HWDATA holds across reads and idles.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_q       <= '0;
            d_valid_q <= 1'b0;
            d_write_q <= 1'b0;
            hwdata_q  <= '0;
        end else if (HREADY) begin
            d_valid_q <= a_q.valid;
            d_write_q <= a_q.write;
            if (a_q.valid && a_q.write) hwdata_q <= DATA_W'(a_q.wdata);
            if (accept) a_q <= cmd_ph;
            else        a_q.valid <= 1'b0;
        end else begin
`ifdef AHB_MASTER_HRESP_EN
            if (err_first) a_q.valid <= 1'b0;
            else
`endif
            if (accept) a_q <= cmd_ph;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_valid    <= 1'b0;
            rsp_write    <= 1'b0;
            rsp_rdata    <= '0;
`ifdef AHB_MASTER_HRESP_EN
            rsp_error    <= 1'b0;
            drop_q       <= 1'b0;
            drop_write_q <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            if (HREADY && d_valid_q) begin
                rsp_valid <= 1'b1;
                rsp_write <= d_write_q;
                rsp_rdata <= d_write_q ? '0 : HRDATA;
`ifdef AHB_MASTER_HRESP_EN
                rsp_error <= HRESP;
`endif
            end
`ifdef AHB_MASTER_HRESP_EN
            else if (drop_q) begin
                rsp_valid <= 1'b1;
                rsp_write <= drop_write_q;
                rsp_rdata <= '0;
                rsp_error <= 1'b1;
                drop_q    <= 1'b0;
            end
            if (err_first) begin
                drop_q       <= 1'b1;
                drop_write_q <= a_q.write;
            end
`endif
        end
    end

    assign HADDR     = ADDR_W'(a_q.addr);
    assign HTRANS    = a_q.valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HWRITE    = a_q.write;
    assign HSIZE     = a_q.size;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DEFAULT;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: bus-phase model, response scoreboard, directed and random traffic.
`timescale 1ns/1ps
module tb_ahb_lite_master;
    import ahb_lite_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_write;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA, HRDATA;
    logic        HREADY;
`ifdef AHB_MASTER_HRESP_EN
    logic        HRESP, rsp_error;
`endif

    ahb_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
`ifdef AHB_MASTER_HRESP_EN
        .rsp_error(rsp_error), .HRESP(HRESP),
`endif
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 HCLK = ~HCLK;
    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [33:0] exp_q[$];      // {error, write, rdata}
    logic [67:0] ap_q[$];       // {write, addr, size, wdata}
    int          acc_cyc_q[$];
    int          rsp_cyc_q[$];
    logic        dp_valid = 1'b0;
    logic [67:0] dp_ent = '0;
    logic        acc_f, pend;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0000_0005 : ((a ^ 32'h5A00_0000) + 32'd1);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = s;
        cmd_wdata = d;
    endtask

    // Called at a negedge where the handshake is certain for the coming edge.
    task automatic push_expected(input logic err);
        logic [31:0] rd;
        rd = (cmd_write || err) ? 32'h0 : rd_data(cmd_addr);
        exp_q.push_back({err, cmd_write, rd});
        ap_q.push_back({cmd_write, cmd_addr, cmd_size, cmd_wdata});
        acc_cyc_q.push_back(cyc + 1);
    endtask

    task automatic wait_accept(input logic err);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge HCLK);
            if (cmd_ready) got = 1'b1;
        end
        if (!got) check("accept_timeout", 64'(got), 64'(1));
        else      push_expected(err);
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        drive_cmd(w, a, s, d);
        wait_accept(1'b0);
    endtask

    task automatic wait_rsp(input int n);
        int i;
        i = 0;
        while (rsp_cyc_q.size() < n && i < 40) begin
            @(posedge HCLK); #2;
            i++;
        end
        check("rsp_count", 64'(rsp_cyc_q.size()), 64'(n));
    endtask

    task automatic clear_logs();
        acc_cyc_q.delete();
        rsp_cyc_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_htrans"},    64'(HTRANS),    64'(HTRANS_IDLE));
        check({tag, "_haddr"},     64'(HADDR),     64'(0));
        check({tag, "_hwrite"},    64'(HWRITE),    64'(0));
        check({tag, "_hsize"},     64'(HSIZE),     64'(0));
        check({tag, "_hwdata"},    64'(HWDATA),    64'(0));
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, "_rsp_write"}, 64'(rsp_write), 64'(0));
        check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    endtask

    // ---------------- bus model + response monitor (negedge) ----------------
    always @(negedge HCLK) begin
        logic [67:0] cur;
        logic [33:0] e;
        logic        ap_done;
        if (!HRESETn) begin
            dp_valid = 1'b0;
            HRDATA   = '0;
        end else begin
            ap_done = 1'b0;
            cur     = '0;
            if (HTRANS == HTRANS_NONSEQ) begin
                if (ap_q.size() == 0) check("nonseq_unexpected", 64'(ap_q.size()), 64'(1));
                else begin
                    cur = ap_q[0];
                    check("haddr",  64'(HADDR),  64'(cur[66:35]));
                    check("hwrite", 64'(HWRITE), 64'(cur[67]));
                    check("hsize",  64'(HSIZE),  64'(cur[34:32]));
                    if (HREADY) begin
                        void'(ap_q.pop_front());
                        ap_done = 1'b1;
                    end
                end
            end else begin
                check("htrans_idle", 64'(HTRANS), 64'(HTRANS_IDLE));
            end
            if (dp_valid && dp_ent[67]) check("hwdata", 64'(HWDATA), 64'(dp_ent[31:0]));
            HRDATA = (dp_valid && !dp_ent[67]) ? rd_data(dp_ent[66:35]) : 32'h0;
            if (HREADY) begin
                dp_valid = ap_done;
                dp_ent   = cur;
            end
            if (rsp_valid) begin
                rsp_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) check("rsp_unexpected", 64'(exp_q.size()), 64'(1));
                else begin
                    e = exp_q.pop_front();
                    check("rsp_write", 64'(rsp_write), 64'(e[32]));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
`ifdef AHB_MASTER_HRESP_EN
                    check("rsp_error", 64'(rsp_error), 64'(e[33]));
`endif
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
        HREADY = 1'b1;
        acc_f = 1'b0; pend = 1'b0;
`ifdef AHB_MASTER_HRESP_EN
        HRESP = 1'b0;
`endif
        HRESETn = 1'b1;
        #1 HRESETn = 1'b0;
        #2 check_reset_outputs("rst");
`ifdef AHB_MASTER_HRESP_EN
        check("rst_rsp_error", 64'(rsp_error), 64'(0));
`endif
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // idle after reset
        repeat (4) begin
            @(negedge HCLK);
            check("idle_htrans", 64'(HTRANS),    64'(HTRANS_IDLE));
            check("idle_haddr",  64'(HADDR),     64'(0));
            check("idle_ready",  64'(cmd_ready), 64'(1));
            check("idle_rsp",    64'(rsp_valid), 64'(0));
        end

        // single zero-wait write
        @(posedge HCLK); #1;
        clear_logs();
        send(1'b1, 32'h4, HSIZE_WORD, 32'hFFFF_FFFE);
        wait_rsp(1);
        if (rsp_cyc_q.size() >= 1) check("single_latency", 64'(rsp_cyc_q[0] - acc_cyc_q[0]), 64'(2));

        // back-to-back write, write, read with zero-wait slave
        clear_logs();
        send(1'b1, 32'h4, HSIZE_WORD, 32'hFFFF_FFFE);
        send(1'b1, 32'h8, HSIZE_WORD, 32'hFFFF_FFFF);
        send(1'b0, 32'h0, HSIZE_WORD, 32'h0);
        wait_rsp(3);
        if (rsp_cyc_q.size() >= 3) begin
            for (int i = 0; i < 3; i++) check("b2b_latency", 64'(rsp_cyc_q[i] - acc_cyc_q[i]), 64'(2));
            for (int i = 0; i < 2; i++) check("b2b_accept_gap", 64'(acc_cyc_q[i+1] - acc_cyc_q[i]), 64'(1));
        end

        // three wait states during the write-0x8 data phase
        clear_logs();
        send(1'b1, 32'h4, HSIZE_WORD, 32'hFFFF_FFFE);
        send(1'b1, 32'h8, HSIZE_WORD, 32'hFFFF_FFFF);
        send(1'b0, 32'h0, HSIZE_WORD, 32'h0);
        HREADY = 1'b0;
        repeat (3) begin
            @(negedge HCLK);
            check("stall_cmd_ready", 64'(cmd_ready), 64'(0));
            check("stall_htrans",    64'(HTRANS),    64'(HTRANS_NONSEQ));
            check("stall_hwdata",    64'(HWDATA),    64'(32'hFFFF_FFFF));
            @(posedge HCLK); #1;
        end
        HREADY = 1'b1;
        wait_rsp(3);
        if (rsp_cyc_q.size() >= 3) begin
            check("stall_lat_w4", 64'(rsp_cyc_q[0] - acc_cyc_q[0]), 64'(2));
            check("stall_lat_w8", 64'(rsp_cyc_q[1] - acc_cyc_q[1]), 64'(5));
            check("stall_lat_rd", 64'(rsp_cyc_q[2] - acc_cyc_q[2]), 64'(5));
        end

        // reset while a read sits in the data phase
        clear_logs();
        send(1'b0, 32'h10, HSIZE_WORD, 32'h0);
        @(posedge HCLK); #3;
        HRESETn = 1'b0;
        #1 check_reset_outputs("midrst");
        exp_q.delete();
        ap_q.delete();
        clear_logs();
        repeat (2) @(posedge HCLK);
        #3 HRESETn = 1'b1;
        repeat (5) @(posedge HCLK);
        #2 check("midrst_no_rsp", 64'(rsp_cyc_q.size()), 64'(0));

`ifdef AHB_MASTER_HRESP_EN
        // two-cycle ERROR on write 0x4 while read 0x0 waits in the address phase
        @(posedge HCLK); #1;
        clear_logs();
        drive_cmd(1'b1, 32'h4, HSIZE_WORD, 32'h1234_5678);
        wait_accept(1'b1);
        drive_cmd(1'b0, 32'h0, HSIZE_WORD, 32'h0);
        wait_accept(1'b1);
        HREADY = 1'b0; HRESP = 1'b1;
        @(negedge HCLK);
        check("err1_htrans", 64'(HTRANS), 64'(HTRANS_NONSEQ));
        @(posedge HCLK); #1;
        HREADY = 1'b1;
        @(negedge HCLK);
        check("err2_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
        @(posedge HCLK); #1;
        HRESP = 1'b0;
        wait_rsp(2);
        if (rsp_cyc_q.size() >= 2) check("err_rsp_gap", 64'(rsp_cyc_q[1] - rsp_cyc_q[0]), 64'(1));
        ap_q.delete();
`endif

        // random traffic with random wait states
        clear_logs();
        for (int i = 0; i < 80; i++) begin
            @(posedge HCLK); #1;
            if (acc_f) begin
                cmd_valid = 1'b0;
                pend      = 1'b0;
                acc_f     = 1'b0;
            end
            HREADY = ($urandom_range(0, 3) != 0);
            if (!pend && $urandom_range(0, 2) != 0) begin
                drive_cmd(1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                          3'($urandom_range(0, 2)), $urandom());
                pend = 1'b1;
            end
            @(negedge HCLK);
            if (cmd_valid && cmd_ready) begin
                push_expected(1'b0);
                acc_f = 1'b1;
            end
        end
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        HREADY    = 1'b1;
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge HCLK);
        #2;
        check("drain_exp", 64'(exp_q.size()), 64'(0));
        check("drain_ap",  64'(ap_q.size()),  64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- Synthesizable AHB-Lite initiator: turns a simple valid/ready command stream into AHB-Lite single transfers (NONSEQ, SINGLE burst).
- Address phase of command N+1 overlaps the data phase of command N.
- Drives register slaves such as the SPI peripheral and returns read data and completion on a response strobe.
- Sits between a local controller (DMA/sequencer) and the AHB-Lite interconnect.

Parameters:
- ADDR_W, 32, HADDR / cmd_addr width.
- DATA_W, 32, HWDATA / HRDATA / cmd_wdata width; only 32 is supported.

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted on a rising edge when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_size  in  3  HSIZE encoding (BYTE=000, HALF=001, WORD=010)
- cmd_wdata  in  DATA_W  write data, already lane-positioned by the caller
- rsp_valid  out  1  one-cycle completion strobe
- rsp_write  out  1  completed transfer was a write
- rsp_rdata  out  DATA_W  read data (zero for writes)
- HADDR  out  ADDR_W
- HTRANS  out  2  IDLE=00, NONSEQ=10 only
- HWRITE  out  1
- HSIZE  out  3
- HBURST  out  3  constant 000
- HPROT  out  4  constant 0011
- HMASTLOCK  out  1  constant 0
- HWDATA  out  DATA_W
- HRDATA  in  DATA_W
- HREADY  in  1  global ready, from the interconnect
- HRESP  in  1  present only with AHB_MASTER_HRESP_EN

Behaviour:
- Reset: HRESETn is asynchronous, active-low; the clock is HCLK.
  - While in reset: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_write=0, rsp_rdata=0.
  - Both internal phase registers are empty.
- Two pipeline stages, each a registered valid, write, size and data: A (address phase, drives HADDR/HTRANS/HWRITE/HSIZE) and D (data phase, drives HWDATA).
- cmd_ready = !A.valid || HREADY (combinational).
- On each edge with HREADY=1:
  - D <= A.
  - A <= the accepted command, or IDLE (A.valid=0) if none is accepted.
- HREADY=0: A and D are frozen, so HADDR/HTRANS/HWRITE/HSIZE/HWDATA hold stable. No command is accepted if A is valid.
- HTRANS = NONSEQ when A.valid, else IDLE.
- HWDATA is driven from D.wdata. It holds its last value when D is empty or a read.
- Completion: an edge with HREADY=1 && D.valid registers rsp_valid=1, rsp_write=D.write, and rsp_rdata=HRDATA (reads) or 0 (writes). rsp_valid is 0 on every other cycle.
- Latency, command accepted at edge E0 with zero-wait slave:
  - NONSEQ in cycle E0..E1.
  - Data in cycle E1..E2.
  - rsp_valid in cycle E2..E3.
- Each wait state adds one cycle.
- Sustained throughput: one transfer per cycle.
- No alignment or size checking; the caller guarantees aligned BYTE, HALF and WORD only.
- Responses are in command order. There is no backpressure on the response side; the consumer must always accept.
- Simultaneous events:
  - cmd accept, D completion and A->D advance occur on the same edge.
  - rsp_valid for command N and NONSEQ for command N+2 may coincide.
- Reset mid-transfer: both stages are discarded immediately and no rsp_valid is issued for in-flight commands.

Optional Feature:
- Macro: AHB_MASTER_HRESP_EN.
- With the macro: HRESP port and rsp_error output (1 bit, reset 0) exist.
  - rsp_error is registered alongside rsp_valid as HRESP at the completing edge.
  - During the first error cycle (HRESP=1, HREADY=0), a pending A transfer is converted to IDLE (A.valid cleared, command dropped).
  - The dropped command yields rsp_valid with rsp_error=1 one cycle after the erroring response.
- Without the macro: no HRESP or rsp_error ports; slaves are assumed to always return OKAY.

Decomposition:
- ahb_lite_pkg holds:
  - HTRANS constants (IDLE, BUSY, NONSEQ, SEQ).
  - HSIZE constants (BYTE, HALF, WORD).
  - HBURST_SINGLE and HPROT_DEFAULT constants.
  - A phase-register struct typedef (valid, write, addr, size, wdata).
- Single module; no sub-module is warranted.

Test Plan:
- Reset, then idle with cmd_valid=0 -> HTRANS=00, HADDR=0, cmd_ready=1, rsp_valid=0 throughout.
- Write WORD 0x4 data 0xFFFFFFFE, zero-wait slave -> HTRANS=10, HADDR=0x4, HWRITE=1 for one cycle; next cycle HWDATA=0xFFFFFFFE; next cycle rsp_valid=1, rsp_write=1.
- Back-to-back write 0x4 (0xFFFFFFFE), write 0x8 (0xFFFFFFFF), read 0x0 with slave returning 0x00000005 -> three consecutive NONSEQ cycles; HWDATA sequence FFFFFFFE, FFFFFFFF; third rsp has rsp_rdata=0x00000005.
- Slave holds HREADY=0 for 3 cycles during the write-0x8 data phase -> HADDR=0x0/NONSEQ and HWDATA=0xFFFFFFFF stay stable; cmd_ready=0; the completion is delayed 3 cycles.
- HRESETn asserted while a read is in the data phase -> outputs return to reset values asynchronously; no rsp_valid after release.
- With AHB_MASTER_HRESP_EN: write 0x4 errors with a two-cycle ERROR response while read 0x0 is in A -> HTRANS goes IDLE in the second error cycle; responses are (write, rsp_error=1) then (read, rsp_error=1).
